noc_tx_arbiter: RTL and testbench

NOC_TX_ARBITER -- requirements
Module: noc_tx_arbiter

---
 rtl/noc_tx_arbiter_if.sv | 29 ++
 rtl/noc_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_noc_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_tx_arbiter_if.sv
// Requester, NoC and Avalon register-port signals of the NoC transmit arbiter.
// The arbiter uses the slave modport; the driving environment uses the master modport.
interface noc_tx_arbiter_if;
    logic [3:0]   req;
    logic [31:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   grant;
    logic         noc_valid;
    logic [7:0]   noc_addr;
    logic [31:0]  noc_data;
    logic         noc_ready;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;

    modport slave (
        input  req, req_addr, req_data, noc_ready,
        input  address, chipselect, write_n, writedata,
        output grant, noc_valid, noc_addr, noc_data, readdata
    );

    modport master (
        output req, req_addr, req_data, noc_ready,
        output address, chipselect, write_n, writedata,
        input  grant, noc_valid, noc_addr, noc_data, readdata
    );
endinterface

// File: rtl/noc_tx_arbiter.sv
// Round-robin arbiter that forwards one of four requesters onto a single NoC port.
// state | meaning
// IDLE  | no transfer held; arbitrate among unmasked requesters when enabled
// SEND  | latched transfer presented on the NoC until noc_ready completes it
module noc_tx_arbiter (
    input  logic              clk,
    input  logic              reset_n,
    noc_tx_arbiter_if.slave   bus
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state;
    state_t      state_next;
    logic        en;
    logic [3:0]  mask;
    logic [1:0]  ptr;
    logic [1:0]  winner;
    logic [1:0]  last;
    logic [15:0] count;
    logic [3:0]  eligible;
    logic [1:0]  pick;
    logic [1:0]  probe;
    logic        found;
    logic        start;
    logic        handshake;
    logic        wr;

    assign wr       = bus.chipselect && !bus.write_n;
    assign eligible = bus.req & ~mask;

    // first eligible index at or above ptr, wrapping 3 -> 0
    always_comb begin
        pick  = ptr;
        probe = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            probe = ptr + 2'(k);
            if (!found && eligible[probe]) begin
                pick  = probe;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    start      = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bus.noc_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.grant = 4'b0000;
        if (reset_n && handshake) begin
            bus.grant[winner] = 1'b1;
        end
    end

    assign bus.noc_valid = (state == SEND);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            winner       <= 2'd0;
            ptr          <= 2'd0;
            last         <= 2'd0;
            en           <= 1'b0;
            mask         <= 4'b0000;
            count        <= 16'd0;
            bus.noc_addr <= 8'h00;
            bus.noc_data <= 32'h0;
        end else begin
            if (start) begin
                winner       <= pick;
                bus.noc_addr <= bus.req_addr[{pick, 3'b000} +: 8];
                bus.noc_data <= bus.req_data[{pick, 5'b00000} +: 32];
            end
            if (handshake) begin
                ptr  <= winner + 2'd1;
                last <= winner;
            end
            if (wr && bus.address == 2'd0) begin
                en   <= bus.writedata[0];
                mask <= bus.writedata[7:4];
            end
            // a clear on the handshake edge takes priority over the increment
            if (wr && bus.address == 2'd2) begin
                count <= 16'd0;
            end else if (handshake) begin
                count <= count + 16'd1;
            end
        end
    end

    always_comb begin
        bus.readdata = 32'h0;
        case (bus.address)
            2'd0:    bus.readdata = {24'h0, mask, 3'b000, en};
            2'd1:    bus.readdata = {20'h0, bus.req, 2'b00, last, 3'b000, (state == SEND)};
            2'd2:    bus.readdata = {16'h0, count};
            default: bus.readdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// Directed bench for noc_tx_arbiter with a transfer scoreboard checked on every grant.
module tb_noc_tx_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    noc_tx_arbiter_if bus ();

    noc_tx_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          idx;
        logic [7:0]  addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    gcnt   = 0;
    int    gcyc[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // every grant must match the oldest expected transfer
    always @(negedge clk) begin
        if (bus.grant !== 4'b0000) begin
            xfer_t       e;
            logic [31:0] eg;
            if (sb.size() == 0) begin
                chk("unexpected_grant", {28'h0, bus.grant}, 32'h0);
            end else begin
                e  = sb.pop_front();
                eg = 32'(1) << e.idx;
                chk("grant_onehot", {28'h0, bus.grant}, eg);
                chk("grant_addr", {24'h0, bus.noc_addr}, {24'h0, e.addr});
                chk("grant_data", bus.noc_data, e.data);
                chk("grant_valid", {31'h0, bus.noc_valid}, 32'h1);
            end
            gcnt++;
            gcyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (bus.grant != 4'b0000) begin
                bus.req = bus.req & ~bus.grant;
                found   = 1'b1;
            end
            step();
        end
        chk(tag, {31'h0, found}, 32'h1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (bus.noc_valid === 1'b1) found = 1'b1;
            else step();
        end
        chk(tag, {31'h0, found}, 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        int          g0;

        bus.req        = 4'b0000;
        bus.req_addr   = 32'h0;
        bus.req_data   = 128'h0;
        bus.noc_ready  = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;

        // reset state and EN=0 holds off a pending request
        do_reset();
        chk("rst_valid", {31'h0, bus.noc_valid}, 32'h0);
        chk("rst_addr", {24'h0, bus.noc_addr}, 32'h0);
        reg_rd(2'd0, rd); chk("rst_ctrl", rd, 32'h0);
        bus.req            = 4'b0001;
        bus.req_addr[7:0]  = 8'h2A;
        bus.req_data[31:0] = 32'hDEADBEEF;
        bus.noc_ready      = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("en0_valid", {31'h0, bus.noc_valid}, 32'h0);
        end
        reg_rd(2'd2, rd); chk("en0_count", rd, 32'h0);
        reg_rd(2'd3, rd); chk("addr3_read", rd, 32'h0);

        // single transfer, one-cycle latency after EN is written
        sb.push_back('{idx: 0, addr: 8'h2A, data: 32'hDEADBEEF});
        g0 = gcnt;
        reg_wr(2'd0, 32'h1);
        chk("latency_pre", {31'h0, bus.noc_valid}, 32'h0);
        step();
        chk("latency_valid", {31'h0, bus.noc_valid}, 32'h1);
        chk("first_grant", {28'h0, bus.grant}, 32'h1);
        wait_grant("first_wait", 4);
        reg_rd(2'd2, rd); chk("first_count", rd, 32'h1);
        reg_rd(2'd1, rd); chk("first_status", rd, 32'h0);
        chk("first_gcnt", gcnt - g0, 1);

        // round robin over four held requests, one grant per two cycles
        do_reset();
        reg_wr(2'd0, 32'h1);
        for (int i = 0; i < 4; i++) begin
            bus.req_addr[8*i +: 8]   = 8'h10 + 8'(i);
            bus.req_data[32*i +: 32] = 32'hA000_0000 + 32'(i);
            sb.push_back('{idx: i, addr: 8'h10 + 8'(i), data: 32'hA000_0000 + 32'(i)});
        end
        g0 = gcnt;
        bus.noc_ready = 1'b1;
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) wait_grant("rr_wait", 4);
        chk("rr_gcnt", gcnt - g0, 4);
        for (int i = gcyc.size() - 3; i < gcyc.size(); i++) begin
            chk("rr_spacing", gcyc[i] - gcyc[i-1], 2);
        end
        reg_rd(2'd2, rd); chk("rr_count", rd, 32'h4);

        // stall in SEND while inputs and EN change underneath
        do_reset();
        reg_wr(2'd0, 32'h1);
        bus.noc_ready        = 1'b0;
        bus.req_addr[23:16]  = 8'h5C;
        bus.req_data[95:64]  = 32'h1234_5678;
        sb.push_back('{idx: 2, addr: 8'h5C, data: 32'h1234_5678});
        g0 = gcnt;
        bus.req = 4'b0100;
        wait_valid("stall_wait", 4);
        for (int k = 0; k < 5; k++) begin
            bus.req_data[95:64] = $urandom;
            chk("stall_valid", {31'h0, bus.noc_valid}, 32'h1);
            chk("stall_addr", {24'h0, bus.noc_addr}, 32'h5C);
            chk("stall_data", bus.noc_data, 32'h1234_5678);
            chk("stall_grant", {28'h0, bus.grant}, 32'h0);
            reg_rd(2'd1, rd); chk("stall_busy", {31'h0, rd[0]}, 32'h1);
            if (k == 1) reg_wr(2'd0, 32'h0);
            else step();
        end
        reg_rd(2'd0, rd); chk("stall_ctrl", rd, 32'h0);
        bus.noc_ready = 1'b1;
        #1;
        chk("stall_grant_rel", {28'h0, bus.grant}, 32'h4);
        wait_grant("stall_done", 2);
        chk("stall_idle", {31'h0, bus.noc_valid}, 32'h0);
        reg_rd(2'd1, rd); chk("stall_status", rd, 32'h20);
        chk("hold_addr", {24'h0, bus.noc_addr}, 32'h5C);
        step();
        step();
        chk("stall_gcnt", gcnt - g0, 1);

        // MASK blocks requester 0, then COUNT wrap and clear-on-handshake
        do_reset();
        bus.req_addr[7:0]   = 8'h30;
        bus.req_data[31:0]  = 32'hB000_0000;
        bus.req_addr[15:8]  = 8'h31;
        bus.req_data[63:32] = 32'hB000_0001;
        sb.push_back('{idx: 1, addr: 8'h31, data: 32'hB000_0001});
        bus.req = 4'b0011;
        reg_wr(2'd0, 32'h11);
        wait_grant("mask_wait", 4);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mask_blocked", {31'h0, bus.noc_valid}, 32'h0);
        end
        reg_rd(2'd0, rd); chk("mask_ctrl", rd, 32'h11);
        reg_rd(2'd2, rd); chk("mask_count", rd, 32'h1);
        reg_rd(2'd1, rd); chk("mask_status", rd, 32'h110);

        force dut.count = 16'hFFFF;
        step();
        release dut.count;
        reg_rd(2'd2, rd); chk("preset_count", rd, 32'hFFFF);
        sb.push_back('{idx: 0, addr: 8'h30, data: 32'hB000_0000});
        reg_wr(2'd0, 32'h1);
        wait_grant("wrap_wait", 4);
        reg_rd(2'd2, rd); chk("wrap_count", rd, 32'h0);

        sb.push_back('{idx: 0, addr: 8'h30, data: 32'hB000_0000});
        g0 = gcnt;
        bus.noc_ready = 1'b0;
        bus.req = 4'b0001;
        wait_valid("clr_wait", 4);
        bus.req = 4'b0000;
        bus.noc_ready = 1'b1;
        reg_wr(2'd2, 32'h5);
        chk("clr_gcnt", gcnt - g0, 1);
        chk("clr_idle", {31'h0, bus.noc_valid}, 32'h0);
        reg_rd(2'd2, rd); chk("clr_count", rd, 32'h0);

        // reset during SEND drops the transfer with no grant
        bus.noc_ready       = 1'b0;
        bus.req_addr[31:24] = 8'hC3;
        bus.req_data[127:96] = 32'hCAFE_0003;
        sb.push_back('{idx: 3, addr: 8'hC3, data: 32'hCAFE_0003});
        bus.req = 4'b1000;
        wait_valid("rst_send_wait", 6);
        g0 = gcnt;
        reset_n = 1'b0;
        bus.noc_ready = 1'b1;
        #1;
        chk("rst_grant", {28'h0, bus.grant}, 32'h0);
        step();
        chk("rst_send_valid", {31'h0, bus.noc_valid}, 32'h0);
        reg_rd(2'd0, rd); chk("rst_send_ctrl", rd, 32'h0);
        reg_rd(2'd2, rd); chk("rst_send_count", rd, 32'h0);
        reset_n = 1'b1;
        step();
        step();
        chk("rst_send_gcnt", gcnt - g0, 0);
        chk("rst_send_sb", sb.size(), 1);
        sb.delete();
        bus.req = 4'b0000;
        step();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
